// File: rtl/mem_stage.sv
// DLX MEM stage: loads/stores over a req/ack data port with big-endian lanes and MEM/WB registers.
// Optional abort of unacknowledged accesses is enabled with MEM_TIMEOUT_EN.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] result_mem,
  input  logic [31:0] store_data_mem,
  input  logic [5:0]  opcode_mem,
  input  logic        memwrite_mem,
  input  logic        memtoreg_mem,
  input  logic        regwrite_mem,
  input  logic [4:0]  towrite_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [31:0] wb_data,
  output logic [4:0]  towrite_wb,
  output logic        regwrite_wb,
  output logic        align_err,
  output logic        bus_err
);
  // state | meaning
  // IDLE  | pass ALU results through, launch aligned memory accesses
  // BUSY  | request outstanding, waiting for dmem_ack (or timeout)
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LBU = 6'h24, OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29;

  state_t      state, state_next;
  logic        mem_op, is_store, is_byte, is_half, is_signed, misaligned, timeout_hit;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc, load_data;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  always_comb begin
    mem_op     = memwrite_mem | memtoreg_mem;
    is_store   = memwrite_mem;
    is_byte    = (opcode_mem == OP_LB) || (opcode_mem == OP_LBU) || (opcode_mem == OP_SB);
    is_half    = (opcode_mem == OP_LH) || (opcode_mem == OP_LHU) || (opcode_mem == OP_SH);
    is_signed  = (opcode_mem == OP_LB) || (opcode_mem == OP_LH);
    misaligned = (is_half && result_mem[0]) ||
                 (!is_byte && !is_half && (result_mem[1:0] != 2'b00));
  end

  // Byte 0 lives in bits 31:24, so lane selection counts down from the MSB.
  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = store_data_mem;
    if (is_byte) begin
      be_calc    = 4'b1000 >> result_mem[1:0];
      wdata_calc = {4{store_data_mem[7:0]}};
    end else if (is_half) begin
      be_calc    = result_mem[1] ? 4'b0011 : 4'b1100;
      wdata_calc = {2{store_data_mem[15:0]}};
    end
  end

  always_comb begin
    case (result_mem[1:0])
      2'd0:    load_byte = dmem_rdata[31:24];
      2'd1:    load_byte = dmem_rdata[23:16];
      2'd2:    load_byte = dmem_rdata[15:8];
      default: load_byte = dmem_rdata[7:0];
    endcase
    load_half = result_mem[1] ? dmem_rdata[15:0] : dmem_rdata[31:16];
    load_data = dmem_rdata;
    if (is_byte)
      load_data = is_signed ? {{24{load_byte[7]}}, load_byte} : {24'd0, load_byte};
    else if (is_half)
      load_data = is_signed ? {{16{load_half[15]}}, load_half} : {16'd0, load_half};
  end

`ifdef MEM_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;

  assign timeout_hit = (state == BUSY) && !dmem_ack && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      bus_err <= 1'b0;
    end else begin
      bus_err <= timeout_hit;
      if (state != BUSY)
        cnt <= '0;
      else if (!dmem_ack)
        cnt <= cnt + CNT_W'(1);
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = TIMEOUT_CYCLES[0] ^ CNT_W[0];
  assign timeout_hit = 1'b0;
  assign bus_err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    mem_stall  = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op && !misaligned) begin
          mem_stall  = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        mem_stall = !dmem_ack && !timeout_hit;
        if (dmem_ack || timeout_hit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_be     <= '0;
      dmem_wdata  <= '0;
      wb_data     <= '0;
      towrite_wb  <= '0;
      regwrite_wb <= 1'b0;
      align_err   <= 1'b0;
    end else begin
      align_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!mem_op) begin
            wb_data     <= result_mem;
            towrite_wb  <= towrite_mem;
            regwrite_wb <= regwrite_mem;
          end else if (misaligned) begin
            align_err   <= 1'b1;
            regwrite_wb <= 1'b0;
          end else begin
            dmem_req    <= 1'b1;
            dmem_we     <= is_store;
            dmem_addr   <= {result_mem[31:2], 2'b00};
            dmem_be     <= be_calc;
            dmem_wdata  <= wdata_calc;
            regwrite_wb <= 1'b0;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            dmem_req   <= 1'b0;
            towrite_wb <= towrite_mem;
            if (is_store) begin
              regwrite_wb <= 1'b0;
            end else begin
              wb_data     <= load_data;
              regwrite_wb <= regwrite_mem;
            end
          end else if (timeout_hit) begin
            dmem_req    <= 1'b0;
            regwrite_wb <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage; writeback expectations are queued at issue and checked at completion.
// Build with MEM_TIMEOUT_EN to exercise the abort path (TIMEOUT_CYCLES=4).
module tb_mem_stage;
`ifdef MEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic        clk = 1'b0, reset = 1'b1;
  logic [31:0] result_mem = '0, store_data_mem = '0, dmem_rdata = '0;
  logic [5:0]  opcode_mem = '0;
  logic        memwrite_mem = 1'b0, memtoreg_mem = 1'b0, regwrite_mem = 1'b0, dmem_ack = 1'b0;
  logic [4:0]  towrite_mem = '0;
  logic        dmem_req, dmem_we, mem_stall, regwrite_wb, align_err, bus_err;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [3:0]  dmem_be;
  logic [4:0]  towrite_wb;

  typedef struct {
    logic [31:0] wb;
    logic [4:0]  rd;
    logic        rw;
    logic        chk_wb;
  } wb_t;
  wb_t sb_q[$];
  int total = 0, bad = 0;

  mem_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .result_mem(result_mem), .store_data_mem(store_data_mem),
    .opcode_mem(opcode_mem), .memwrite_mem(memwrite_mem), .memtoreg_mem(memtoreg_mem),
    .regwrite_mem(regwrite_mem), .towrite_mem(towrite_mem), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .wb_data(wb_data),
    .towrite_wb(towrite_wb), .regwrite_wb(regwrite_wb), .align_err(align_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sd,
                       input logic mw, input logic mr, input logic rw, input logic [4:0] rd);
    opcode_mem = op; result_mem = addr; store_data_mem = sd;
    memwrite_mem = mw; memtoreg_mem = mr; regwrite_mem = rw; towrite_mem = rd;
  endtask

  task automatic drive_nop();
    drive(6'h00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic pop_check(input string name);
    wb_t e;
    total++;
    if (sb_q.size() == 0) begin
      bad++; $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      if (towrite_wb !== e.rd || regwrite_wb !== e.rw) begin
        bad++; $display("FAIL %s wb ctrl: got rd=%0d rw=%b want rd=%0d rw=%b",
                        name, towrite_wb, regwrite_wb, e.rd, e.rw);
      end
      if (e.chk_wb) begin
        total++;
        if (wb_data !== e.wb) begin
          bad++; $display("FAIL %s wb_data: got %h want %h", name, wb_data, e.wb);
        end
      end
    end
  endtask

  // Entered and left at posedge+1; a following call continues back-to-back.
  task automatic run_mem(input string name, input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] sd, input logic mw, input logic mr, input logic rw,
                         input logic [4:0] rd, input int waits, input logic [31:0] rdata,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_wb);
    wb_t e;
    int stalls = 0;
    e.wb = exp_wb; e.rd = rd; e.rw = mw ? 1'b0 : rw; e.chk_wb = !mw;
    sb_q.push_back(e);
    drive(op, addr, sd, mw, mr, rw, rd);
    @(negedge clk);
    if (mem_stall) stalls++;
    total++;
    if (dmem_req !== 1'b0) begin
      bad++; $display("FAIL %s launch req: got %b want 0", name, dmem_req);
    end
    @(posedge clk); #1;
    total++;
    if (dmem_req !== 1'b1 || dmem_we !== mw || dmem_addr !== (addr & 32'hFFFF_FFFC) ||
        dmem_be !== exp_be) begin
      bad++; $display("FAIL %s request: got req=%b we=%b addr=%h be=%b want req=1 we=%b addr=%h be=%b",
                      name, dmem_req, dmem_we, dmem_addr, dmem_be, mw, addr & 32'hFFFF_FFFC, exp_be);
    end
    if (mw) begin
      total++;
      if (dmem_wdata !== exp_wdata) begin
        bad++; $display("FAIL %s wdata: got %h want %h", name, dmem_wdata, exp_wdata);
      end
    end
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      if (mem_stall) stalls++;
      total++;
      if (dmem_req !== 1'b1 || bus_err !== 1'b0) begin
        bad++; $display("FAIL %s wait: got req=%b bus_err=%b want 1/0", name, dmem_req, bus_err);
      end
      @(posedge clk); #1;
    end
    dmem_ack = 1'b1; dmem_rdata = rdata;
    @(negedge clk);
    if (mem_stall) stalls++;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    drive_nop();
    total++;
    if (dmem_req !== 1'b0) begin
      bad++; $display("FAIL %s req drop: got %b want 0", name, dmem_req);
    end
    pop_check(name);
    total++;
    if (stalls != waits + 1) begin
      bad++; $display("FAIL %s stall cycles: got %0d want %0d", name, stalls, waits + 1);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    total++;
    if (dmem_req !== 0 || dmem_we !== 0 || dmem_be !== 0 || dmem_addr !== 0 || dmem_wdata !== 0 ||
        wb_data !== 0 || towrite_wb !== 0 || regwrite_wb !== 0 || align_err !== 0 || bus_err !== 0) begin
      bad++; $display("FAIL %s: outputs not cleared req=%b we=%b be=%b addr=%h wd=%h wb=%h rd=%0d rw=%b ae=%b be=%b want all 0",
                      name, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, wb_data,
                      towrite_wb, regwrite_wb, align_err, bus_err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_nop();
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (mem_stall !== 1'b0) begin
      bad++; $display("FAIL reset stall: got %b want 0", mem_stall);
    end
    @(posedge clk); #1;
  endtask

  task automatic alu_op(input string name, input logic [31:0] res, input logic [4:0] rd,
                        input logic rw);
    wb_t e;
    e.wb = res; e.rd = rd; e.rw = rw; e.chk_wb = 1'b1;
    sb_q.push_back(e);
    drive(6'h00, res, 32'h0, 1'b0, 1'b0, rw, rd);
    @(negedge clk);
    total++;
    if (mem_stall !== 1'b0 || dmem_req !== 1'b0) begin
      bad++; $display("FAIL %s stall/req: got %b/%b want 0/0", name, mem_stall, dmem_req);
    end
    @(posedge clk); #1;
    pop_check(name);
  endtask

  task automatic test_alu();
    alu_op("add", 32'h0000_1234, 5'd5, 1'b1);
    alu_op("alu_norw", 32'hA5A5_0F0F, 5'd31, 1'b0);
    drive_nop();
  endtask

  task automatic test_stores();
    run_mem("sw", 6'h2B, 32'h100, 32'hDEAD_BEEF, 1, 0, 1, 5'd4, 2, 32'h0, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    run_mem("sh", 6'h29, 32'h202, 32'h0000_ABCD, 1, 0, 0, 5'd6, 0, 32'h0, 4'b0011, 32'hABCD_ABCD, 32'h0);
    run_mem("sb", 6'h28, 32'h102, 32'h1234_56A5, 1, 0, 0, 5'd8, 1, 32'h0, 4'b0010, 32'hA5A5_A5A5, 32'h0);
    run_mem("st_wins", 6'h2B, 32'h300, 32'h0BAD_F00D, 1, 1, 1, 5'd9, 0, 32'hFFFF_FFFF, 4'b1111, 32'h0BAD_F00D, 32'h0);
  endtask

  task automatic test_loads();
    run_mem("lb", 6'h20, 32'h103, 32'h0, 0, 1, 1, 5'd7, 0, 32'h1122_3380, 4'b0001, 32'h0, 32'hFFFF_FF80);
    run_mem("lb_l1", 6'h20, 32'h101, 32'h0, 0, 1, 1, 5'd10, 0, 32'h11F0_2233, 4'b0100, 32'h0, 32'hFFFF_FFF0);
    run_mem("lh", 6'h21, 32'h202, 32'h0, 0, 1, 1, 5'd11, 1, 32'h1122_8001, 4'b0011, 32'h0, 32'hFFFF_8001);
    run_mem("lhu", 6'h25, 32'h200, 32'h0, 0, 1, 1, 5'd12, 0, 32'h8001_1234, 4'b1100, 32'h0, 32'h0000_8001);
    run_mem("lw", 6'h23, 32'h204, 32'h0, 0, 1, 1, 5'd13, 3, 32'hCAFE_F00D, 4'b1111, 32'h0, 32'hCAFE_F00D);
    run_mem("other_op_word", 6'h3F, 32'h208, 32'h0, 0, 1, 1, 5'd14, 0, 32'h1357_9BDF, 4'b1111, 32'h0, 32'h1357_9BDF);
  endtask

  task automatic test_back_to_back();
    run_mem("b2b_lb", 6'h20, 32'h103, 32'h0, 0, 1, 1, 5'd1, 0, 32'h1122_3380, 4'b0001, 32'h0, 32'hFFFF_FF80);
    run_mem("b2b_lbu", 6'h24, 32'h103, 32'h0, 0, 1, 1, 5'd2, 0, 32'h1122_3380, 4'b0001, 32'h0, 32'h0000_0080);
    run_mem("b2b_sw", 6'h2B, 32'h40C, 32'h7654_3210, 1, 0, 0, 5'd3, 0, 32'h0, 4'b1111, 32'h7654_3210, 32'h0);
  endtask

  task automatic misaligned_op(input string name, input logic [5:0] op, input logic [31:0] addr,
                               input logic mw, input logic mr);
    alu_op({name, "_pre"}, 32'h55, 5'd3, 1'b1);
    drive(op, addr, 32'h1234_5678, mw, mr, 1'b1, 5'd9);
    @(negedge clk);
    total++;
    if (mem_stall !== 1'b0 || dmem_req !== 1'b0) begin
      bad++; $display("FAIL %s stall/req: got %b/%b want 0/0", name, mem_stall, dmem_req);
    end
    @(posedge clk); #1;
    drive_nop();
    total++;
    if (align_err !== 1'b1 || regwrite_wb !== 1'b0 || dmem_req !== 1'b0) begin
      bad++; $display("FAIL %s pulse: got ae=%b rw=%b req=%b want 1/0/0", name, align_err, regwrite_wb, dmem_req);
    end
    @(posedge clk); #1;
    total++;
    if (align_err !== 1'b0 || dmem_req !== 1'b0) begin
      bad++; $display("FAIL %s pulse end: got ae=%b req=%b want 0/0", name, align_err, dmem_req);
    end
  endtask

  task automatic test_misaligned();
    misaligned_op("lh_odd", 6'h21, 32'h201, 1'b0, 1'b1);
    misaligned_op("lw_half", 6'h23, 32'h102, 1'b0, 1'b1);
    misaligned_op("sw_byte", 6'h2B, 32'h101, 1'b1, 1'b0);
  endtask

  task automatic test_reset_busy();
    drive(6'h23, 32'h400, 32'h0, 1'b0, 1'b1, 1'b1, 5'd15);
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (dmem_req !== 1'b1) begin
      bad++; $display("FAIL rst_busy req: got %b want 1", dmem_req);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    drive_nop();
    check_idle_outputs("rst_busy");
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    total++;
    if (mem_stall !== 1'b0) begin
      bad++; $display("FAIL rst_busy late ack stall: got %b want 0", mem_stall);
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    check_idle_outputs("rst_busy late ack");
    alu_op("rst_busy_idle", 32'h77, 5'd2, 1'b1);
    drive_nop();
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int stalls = 0;
    alu_op("to_pre", 32'h99, 5'd4, 1'b1);
    drive(6'h23, 32'h500, 32'h0, 1'b0, 1'b1, 1'b1, 5'd16);
    @(posedge clk); #1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (mem_stall) stalls++;
      total++;
      if (mem_stall !== (i < 4)) begin
        bad++; $display("FAIL timeout stall busy%0d: got %b want %b", i, mem_stall, i < 4);
      end
      @(posedge clk); #1;
    end
    drive_nop();
    total++;
    if (bus_err !== 1'b1 || dmem_req !== 1'b0 || regwrite_wb !== 1'b0) begin
      bad++; $display("FAIL timeout abort: got be=%b req=%b rw=%b want 1/0/0", bus_err, dmem_req, regwrite_wb);
    end
    @(posedge clk); #1;
    total++;
    if (bus_err !== 1'b0 || stalls != 3) begin
      bad++; $display("FAIL timeout pulse: got be=%b stalls=%0d want 0/3", bus_err, stalls);
    end
  endtask
`else
  task automatic test_long_wait();
    run_mem("lw_long", 6'h23, 32'h600, 32'h0, 0, 1, 1, 5'd17, 20, 32'h2468_ACE0, 4'b1111, 32'h0, 32'h2468_ACE0);
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_stores();
    test_loads();
    test_back_to_back();
    test_misaligned();
    test_reset_busy();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
